fifo_wptr_full: RTL and testbench

- Write-side pointer and flag manager for the team's async FIFO. It lives in the write clock domain.
- Maintains the binary write pointer and drives the RAM write address.
- Publishes a registered Gray-coded write pointer to the read domain.
- Synchronises the read domain's Gray pointer and converts it to binary internally (the function the FIFO's Gray-to-binary stage performs). From it, derives full, fill count and a sticky overflow flag.

---
 rtl/fifo_wptr_full.sv | 112 +++++++++++
 tb/tb_fifo_wptr_full.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_wptr_full.sv
// Write-domain pointer/flag manager for the async FIFO: binary and Gray write pointers,
// read-pointer synchroniser, full, fill count and sticky overflow. Optional ALMOST_FULL_EN adds almost_full.
module fifo_wptr_full #(
   parameter int ADDR_W      = 4,
   parameter int SYNC_STAGES = 2,
   parameter int AF_LEVEL    = 12
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [ADDR_W:0]   rd_ptr_gray,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [ADDR_W:0]   wr_ptr_gray,
   output logic              wr_accept,
   output logic              full,
   output logic [ADDR_W:0]   wr_count,
   output logic              overflow
`ifdef ALMOST_FULL_EN
   ,
   output logic              almost_full
`endif
);

   generate
      if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
         $error("fifo_wptr_full: SYNC_STAGES must be in 2..4");
      end
      if (ADDR_W < 2) begin : g_bad_addr
         $error("fifo_wptr_full: ADDR_W must be at least 2");
      end
   endgenerate

   logic [ADDR_W:0] rq_q [SYNC_STAGES];
   logic [ADDR_W:0] rsync;
   logic [ADDR_W:0] rbin_sync;
   logic [ADDR_W:0] wbin_q, wbin_d;
   logic [ADDR_W:0] wgray_q, wgray_d;
   logic [ADDR_W:0] count_q, count_d;
   logic            full_q, full_d;
   logic            ovf_q, ovf_d;

   assign rsync = rq_q[SYNC_STAGES-1];

   always_comb begin
      rbin_sync = '0;
      for (int k = 0; k <= ADDR_W; k++) begin
         rbin_sync[k] = ^(rsync >> k);
      end
   end

   assign wr_accept = wr_en & ~full_q;
   assign wbin_d    = wbin_q + {{ADDR_W{1'b0}}, wr_accept};
   assign wgray_d   = wbin_d ^ (wbin_d >> 1);
   // Full when the write pointer is one lap ahead: top two Gray bits inverted, rest equal.
   assign full_d    = (wgray_d == {~rsync[ADDR_W:ADDR_W-1], rsync[ADDR_W-2:0]});
   assign count_d   = wbin_d - rbin_sync;
   assign ovf_d     = ovf_q | (wr_en & full_q);

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            rq_q[i] <= '0;
         end
         wbin_q  <= '0;
         wgray_q <= '0;
         count_q <= '0;
         full_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         rq_q[0] <= rd_ptr_gray;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            rq_q[i] <= rq_q[i-1];
         end
         wbin_q  <= wbin_d;
         wgray_q <= wgray_d;
         count_q <= count_d;
         full_q  <= full_d;
         ovf_q   <= ovf_d;
      end
   end

   assign wr_addr     = wbin_q[ADDR_W-1:0];
   assign wr_ptr_gray = wgray_q;
   assign full        = full_q;
   assign wr_count    = count_q;
   assign overflow    = ovf_q;

`ifdef ALMOST_FULL_EN
   generate
      if (AF_LEVEL == 0 || AF_LEVEL > (1 << ADDR_W)) begin : g_bad_af
         $error("fifo_wptr_full: AF_LEVEL must be in 1..2^ADDR_W");
      end
   endgenerate

   localparam logic [ADDR_W:0] AF_LVL = AF_LEVEL[ADDR_W:0];

   logic af_q, af_d;

   assign af_d = (count_d >= AF_LVL);

   always_ff @(posedge clk) begin
      if (rst) begin
         af_q <= 1'b0;
      end else begin
         af_q <= af_d;
      end
   end

   assign almost_full = af_q;
`endif

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Self-checking bench for fifo_wptr_full (ADDR_W=4, SYNC_STAGES=2): directed plan steps plus random
// traffic against an occupancy model. Define ALMOST_FULL_EN to also exercise almost_full.
module tb_fifo_wptr_full;

   logic       clk;
   logic       rst;
   logic       wr_en;
   logic [4:0] rd_ptr_gray;
   logic [3:0] wr_addr;
   logic [4:0] wr_ptr_gray;
   logic       wr_accept;
   logic       full;
   logic [4:0] wr_count;
   logic       overflow;
`ifdef ALMOST_FULL_EN
   logic       almost_full;
`endif

   fifo_wptr_full #(.ADDR_W(4), .SYNC_STAGES(2), .AF_LEVEL(12)) dut (
      .clk         (clk),
      .rst         (rst),
      .wr_en       (wr_en),
      .rd_ptr_gray (rd_ptr_gray),
      .wr_addr     (wr_addr),
      .wr_ptr_gray (wr_ptr_gray),
      .wr_accept   (wr_accept),
      .full        (full),
      .wr_count    (wr_count),
      .overflow    (overflow)
`ifdef ALMOST_FULL_EN
      ,
      .almost_full (almost_full)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Occupancy model: pointers as plain integers mod 32; the read pointer seen by the
   // write side lags the driven value by two edges.
   int  m_wptr = 0;
   int  m_rsee = 0;
   int  m_rpipe = 0;
   int  m_cnt  = 0;
   bit  m_full = 0;
   bit  m_ovf  = 0;
   bit  m_af   = 0;
   bit  saw_full = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [4:0] to_gray(input int v);
      logic [4:0] b;
      b = 5'(v % 32);
      return b ^ (b >> 1);
   endfunction

   task automatic step(input bit we, input int rtot, input bit r);
      bit acc;
      wr_en       = we;
      rst         = r;
      rd_ptr_gray = to_gray(rtot);
      #1;
      if (!r) check("wr_accept", 32'(wr_accept), 32'(we && !m_full));
      @(posedge clk);
      if (r) begin
         m_wptr = 0; m_rsee = 0; m_rpipe = 0; m_cnt = 0;
         m_full = 0; m_ovf = 0; m_af = 0;
      end else begin
         acc    = we && !m_full;
         m_ovf  = m_ovf || (we && m_full);
         m_wptr = (m_wptr + int'(acc)) % 32;
         m_cnt  = (m_wptr - m_rsee + 32) % 32;
         m_full = (m_cnt == 16);
         m_af   = (m_cnt >= 12);
         m_rsee = m_rpipe;
         m_rpipe = rtot % 32;
      end
      if (m_full) saw_full = 1;
      #1;
      check("wr_addr",     32'(wr_addr),     32'(m_wptr % 16));
      check("wr_ptr_gray", 32'(wr_ptr_gray), 32'(to_gray(m_wptr)));
      check("full",        32'(full),        32'(m_full));
      check("wr_count",    32'(wr_count),    32'(m_cnt));
      check("overflow",    32'(overflow),    32'(m_ovf));
`ifdef ALMOST_FULL_EN
      check("almost_full", 32'(almost_full), 32'(m_af));
`endif
   endtask

   initial begin
      int wtot;
      int rtot;
      wr_en = 1'b0;
      rst = 1'b1;
      rd_ptr_gray = '0;

      // Reset held 3 cycles with wr_en asserted
      for (int i = 0; i < 3; i++) step(1, 0, 1);
      check("reset_wr_addr", 32'(wr_addr), 32'd0);
      check("reset_full",    32'(full),    32'd0);
      check("reset_count",   32'(wr_count), 32'd0);

      // Fill: 16 writes, first accepted on the first cycle after release
      for (int i = 0; i < 16; i++) begin
         check("fill_addr_pre", 32'(wr_addr), 32'(i));
         step(1, 0, 0);
      end
      check("fill_full",  32'(full),        32'd1);
      check("fill_count", 32'(wr_count),    32'd16);
      check("fill_gray",  32'(wr_ptr_gray), 32'h18);

      // Overflow while full, then sticky through idle
      step(1, 0, 0);
      step(1, 0, 0);
      check("ovf_addr", 32'(wr_addr),  32'd0);
      check("ovf_flag", 32'(overflow), 32'd1);
      for (int i = 0; i < 10; i++) step(0, 0, 0);
      check("ovf_sticky", 32'(overflow), 32'd1);

      // Drain visibility: one read shows up on the third edge
      step(0, 1, 0);
      step(0, 1, 0);
      check("drain_still_full", 32'(full), 32'd1);
      step(0, 1, 0);
      check("drain_full",  32'(full),     32'd0);
      check("drain_count", 32'(wr_count), 32'd15);
      step(1, 1, 0);
      check("refill_full", 32'(full), 32'd1);

      // Wrap: reader keeps pace, pointer passes 31 -> 0
      step(0, 0, 1);
      saw_full = 0;
      for (int i = 0; i < 40; i++) step(1, i, 0);
      check("wrap_addr",     32'(wr_addr),  32'd8);
      check("wrap_no_full",  32'(saw_full), 32'd0);
      check("wrap_overflow", 32'(overflow), 32'd0);

`ifdef ALMOST_FULL_EN
      step(0, 0, 1);
      for (int i = 0; i < 11; i++) step(1, 0, 0);
      check("af_11", 32'(almost_full), 32'd0);
      step(1, 0, 0);
      check("af_12",      32'(almost_full), 32'd1);
      check("af_12_full", 32'(full),        32'd0);
`endif

      // Random traffic: write-heavy then read-heavy; the reader never passes the writer
      step(0, 0, 1);
      wtot = 0;
      rtot = 0;
      for (int i = 0; i < 400; i++) begin
         bit we;
         bit rd;
         if (i < 200) begin
            we = ($urandom_range(0, 3) != 0);
            rd = ($urandom_range(0, 2) == 0);
         end else begin
            we = ($urandom_range(0, 2) == 0);
            rd = ($urandom_range(0, 3) != 0);
         end
         if (rd && rtot < wtot) rtot++;
         if (we && !m_full) wtot++;
         step(we, rtot, 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
